// File: rtl/accel_pkg.sv
// Shared types for filtered accelerometer samples, used by the signal path
// outputs and the sample FIFO.
package accel_pkg;

    localparam int AXIS_W   = 16;
    localparam int SAMPLE_W = 3 * AXIS_W;

    typedef struct packed {
        logic [AXIS_W-1:0] x;
        logic [AXIS_W-1:0] y;
        logic [AXIS_W-1:0] z;
    } accel_sample_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample storage: one synchronous write port and a registered
// read port, shaped so synthesis can map it onto block RAM.
module sample_ram
    import accel_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  accel_sample_t wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output accel_sample_t rdata
);

    accel_sample_t mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-first: a same-address write in the same cycle returns the old entry,
    // which is what a pop from a full buffer needs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/accel_sample_fifo.sv
// Circular buffer of filtered x/y/z samples between the filter signal path and
// the bus reader, with occupancy, watermark and overflow accounting.
module accel_sample_fifo
    import accel_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int WATERMARK = 8
) (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    input  logic                     sample_valid,
    input  logic [AXIS_W-1:0]        x_in,
    input  logic [AXIS_W-1:0]        y_in,
    input  logic [AXIS_W-1:0]        z_in,
    input  logic                     rd_en,
    input  logic                     clear,
    output logic                     rd_valid,
    output logic [AXIS_W-1:0]        rd_x,
    output logic [AXIS_W-1:0]        rd_y,
    output logic [AXIS_W-1:0]        rd_z,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     watermark_irq,
    output logic                     overflow,
    output logic [7:0]               overflow_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] WM_C    = CW'(WATERMARK);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;
    logic          drop;
    logic          wr_fire;
    logic          rd_fire;
    accel_sample_t wdata;
    accel_sample_t rdata;

    assign empty         = (count == '0);
    assign full          = (count == DEPTH_C);
    assign watermark_irq = (count >= WM_C);

    // A pop on a full buffer frees the slot the incoming sample then takes.
    assign pop_ok  = rd_en && !empty;
    assign push_ok = sample_valid && (!full || pop_ok);
    assign drop    = sample_valid && full && !pop_ok;
    assign wr_fire = push_ok && !clear;
    assign rd_fire = pop_ok && !clear;

    assign wdata = {x_in, y_in, z_in};
    assign rd_x  = rdata.x;
    assign rd_y  = rdata.y;
    assign rd_z  = rdata.z;

    sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .we      (wr_fire),
        .waddr   (wr_ptr),
        .wdata   (wdata),
        .re      (rd_fire),
        .raddr   (rd_ptr),
        .rdata   (rdata)
    );

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            rd_valid       <= 1'b0;
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else if (clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            rd_valid       <= 1'b0;
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else begin
            rd_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (overflow_count != 8'hFF) begin
                    overflow_count <= overflow_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_accel_sample_fifo.sv
// Directed scoreboard bench for accel_sample_fifo with DEPTH=16, WATERMARK=8.
module tb_accel_sample_fifo;
    import accel_pkg::*;

    localparam int DEPTH = 16;
    localparam int WM    = 8;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        sample_valid;
    logic [15:0] x_in, y_in, z_in;
    logic        rd_en;
    logic        clear;
    logic        rd_valid;
    logic [15:0] rd_x, rd_y, rd_z;
    logic [4:0]  count;
    logic        empty, full, watermark_irq, overflow;
    logic [7:0]  overflow_count;

    int total = 0;
    int bad   = 0;

    accel_sample_t sb[$];
    int            exp_count = 0;
    int            exp_ovc   = 0;
    logic          exp_ovf   = 1'b0;
    accel_sample_t last_pop  = '0;

    always #5 sys_clk = ~sys_clk;

    accel_sample_fifo #(
        .DEPTH     (DEPTH),
        .WATERMARK (WM)
    ) dut (
        .sys_clk        (sys_clk),
        .reset_n        (reset_n),
        .sample_valid   (sample_valid),
        .x_in           (x_in),
        .y_in           (y_in),
        .z_in           (z_in),
        .rd_en          (rd_en),
        .clear          (clear),
        .rd_valid       (rd_valid),
        .rd_x           (rd_x),
        .rd_y           (rd_y),
        .rd_z           (rd_z),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .watermark_irq  (watermark_irq),
        .overflow       (overflow),
        .overflow_count (overflow_count)
    );

    task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, driven after a falling edge and checked at the next one.
    task automatic applyStimulus(input logic sv, input accel_sample_t s, input logic re);
        logic          pop_acc;
        logic          push_acc;
        accel_sample_t exp_data;
        pop_acc  = re && (exp_count > 0);
        push_acc = sv && ((exp_count < DEPTH) || pop_acc);
        exp_data = last_pop;
        if (pop_acc) begin
            exp_data = sb.pop_front();
            last_pop = exp_data;
            exp_count--;
        end
        if (push_acc) begin
            sb.push_back(s);
            exp_count++;
        end else if (sv) begin
            exp_ovf = 1'b1;
            if (exp_ovc < 255) exp_ovc++;
        end
        sample_valid = sv;
        {x_in, y_in, z_in} = s;
        rd_en = re;
        @(negedge sys_clk);
        sample_valid = 1'b0;
        rd_en = 1'b0;
        checkOutput("rd_valid", 48'(rd_valid), 48'(pop_acc));
        checkOutput("rd_data", {rd_x, rd_y, rd_z}, exp_data);
        checkOutput("count", 48'(count), 48'(exp_count));
        checkOutput("overflow_count", 48'(overflow_count), 48'(exp_ovc));
        checkOutput("overflow", 48'(overflow), 48'(exp_ovf));
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, ".empty"}, 48'(empty), 48'(exp_count == 0));
        checkOutput({tag, ".full"}, 48'(full), 48'(exp_count == DEPTH));
        checkOutput({tag, ".wm"}, 48'(watermark_irq), 48'(exp_count >= WM));
    endtask

    initial begin
        accel_sample_t s;
        reset_n = 1'b0;
        sample_valid = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
        x_in = '0;
        y_in = '0;
        z_in = '0;
        #23;
        @(negedge sys_clk);
        reset_n = 1'b1;
        $display("[TB] reset released");

        checkFlags("reset");
        checkOutput("reset.count", 48'(count), 48'd0);
        checkOutput("reset.rd_valid", 48'(rd_valid), 48'd0);
        checkOutput("reset.rd_data", {rd_x, rd_y, rd_z}, 48'd0);
        checkOutput("reset.ovf", 48'(overflow), 48'd0);
        checkOutput("reset.ovc", 48'(overflow_count), 48'd0);

        applyStimulus(1'b0, '0, 1'b1);

        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, {16'(i), 16'h8000, 16'hFFFF}, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkFlags("after3");

        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, {16'(16'h0100 + i), 16'(i), 16'hFFFF - 16'(i)}, 1'b0);
        end
        checkOutput("wm.below", 48'(watermark_irq), 48'd0);
        applyStimulus(1'b1, {16'h0108, 16'h0008, 16'hFFF7}, 1'b0);
        checkOutput("wm.rise", 48'(watermark_irq), 48'd1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("wm.fall", 48'(watermark_irq), 48'd0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkFlags("wm.drained");

        for (int i = 0; i < DEPTH; i++) begin
            s.x = 16'(i * 16'h0111);
            s.y = ~s.x;
            s.z = 16'(16'h8000 + i);
            applyStimulus(1'b1, s, 1'b0);
        end
        checkFlags("filled");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, {16'hDEAD, 16'(i), 16'hBEEF}, 1'b0);
        end
        checkOutput("ovf.three", 48'(overflow_count), 48'd3);

        applyStimulus(1'b1, {16'h1234, 16'h5678, 16'h9ABC}, 1'b1);
        checkOutput("fullpp.count", 48'(count), 48'd16);
        checkOutput("fullpp.ovc", 48'(overflow_count), 48'd3);

        for (int i = 3; i < 300; i++) begin
            applyStimulus(1'b1, {16'hDEAD, 16'(i), 16'hBEEF}, 1'b0);
        end
        checkOutput("ovf.sat", 48'(overflow_count), 48'd255);
        checkFlags("ovf");

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("drain.last_x", 48'(rd_x), 48'h1234);
        checkFlags("drained");

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, {16'(16'h0200 + i), 16'h7FFF, 16'h0000}, 1'b0);
        end
        checkOutput("preclear.count", 48'(count), 48'd5);
        sample_valid = 1'b1;
        rd_en = 1'b1;
        clear = 1'b1;
        @(negedge sys_clk);
        sample_valid = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
        sb.delete();
        exp_count = 0;
        exp_ovc = 0;
        exp_ovf = 1'b0;
        checkOutput("clear.count", 48'(count), 48'd0);
        checkOutput("clear.rd_valid", 48'(rd_valid), 48'd0);
        checkOutput("clear.ovf", 48'(overflow), 48'd0);
        checkOutput("clear.ovc", 48'(overflow_count), 48'd0);
        checkOutput("clear.rd_data", {rd_x, rd_y, rd_z}, last_pop);
        checkFlags("clear");

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, {16'(16'h0300 + i), 16'h0001, 16'h0002}, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1);
        rd_en = 1'b1;
        @(posedge sys_clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst.count", 48'(count), 48'd0);
        checkOutput("arst.empty", 48'(empty), 48'd1);
        checkOutput("arst.full", 48'(full), 48'd0);
        checkOutput("arst.wm", 48'(watermark_irq), 48'd0);
        checkOutput("arst.rd_valid", 48'(rd_valid), 48'd0);
        checkOutput("arst.rd_data", {rd_x, rd_y, rd_z}, 48'd0);
        checkOutput("arst.ovf", 48'(overflow), 48'd0);
        checkOutput("arst.ovc", 48'(overflow_count), 48'd0);
        rd_en = 1'b0;
        @(negedge sys_clk);
        reset_n = 1'b1;
        @(negedge sys_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accel_sample_fifo.md
# accel_sample_fifo

Buffers filtered three-axis accelerometer samples between the 16-tap filter signal path and the bus-side reader. Each completed filter result (x/y/z, 16 bits each) is captured on the signal path's one-cycle `data_interrupt` pulse and stored as one 48-bit entry. The bus master drains entries at its own pace through a pop/valid handshake. The block adds occupancy, watermark-interrupt and overflow accounting, so no sample is lost silently.

## Interface
Parameters:
- `DEPTH`, 16, number of stored samples; power of two, 4..64.
- `WATERMARK`, 8, occupancy at or above which `watermark_irq` asserts; 1..DEPTH.

Ports:
- `sys_clk`  in  1  sole clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  one-cycle capture strobe; driven from signal path `data_interrupt`.
- `x_in`, `y_in`, `z_in`  in  16 each  filtered axis data; stable while `sample_valid` is high.
- `rd_en`  in  1  pop request from bus side.
- `rd_valid`  out  1  one-cycle pulse; `rd_x/rd_y/rd_z` hold a popped entry.
- `rd_x`, `rd_y`, `rd_z`  out  16 each  registered output entry.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `empty`, `full`  out  1 each  occupancy flags.
- `watermark_irq`  out  1  level; high while `count >= WATERMARK`.
- `overflow`  out  1  sticky; set when a sample is dropped.
- `overflow_count`  out  8  dropped-sample count; saturates at 255.
- `clear`  in  1  synchronous flush.

## Operation
- Storage: circular buffer of DEPTH entries. Write and read pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is held in a separate counter.
- Push: `sample_valid` with `!full` writes {x_in,y_in,z_in} at the write pointer, then advances it.
- Overflow: `sample_valid` with `full` and no same-cycle pop drops the *new* sample. Stored data is unchanged. `overflow` is set and `overflow_count` increments, holding at 255.
- Pop: `rd_en` with `!empty` reads the entry at the read pointer into the `rd_*` registers, advances the read pointer and pulses `rd_valid` next cycle. `rd_en` while empty is ignored: no `rd_valid`, no state change.
- Simultaneous push and pop, not empty: both occur and `count` is unchanged. When full, the pop frees a slot and the push is accepted; no overflow is recorded.
- Simultaneous push and pop, empty: the push is accepted. The pop is ignored (no bypass), and `count` becomes 1.
- `clear`: zeroes both pointers, `count`, `overflow` and `overflow_count`. It takes priority over any same-cycle push or pop. `rd_valid` is 0 that cycle; `rd_*` data registers hold their value.
- Flags are derived from the registered `count`: `empty` = (count==0), `full` = (count==DEPTH), `watermark_irq` = (count>=WATERMARK).
- Entries carry two's-complement axis data unchanged; no arithmetic is applied to the payload.

## Timing
- Reset values:
  - `count` = 0, `empty` = 1, `full` = 0.
  - `watermark_irq` = 0, `overflow` = 0, `overflow_count` = 0.
  - `rd_valid` = 0, `rd_x/rd_y/rd_z` = 0, pointers = 0.
- Reset asserted mid-operation discards all contents immediately, asynchronously. Deassertion is synchronised externally.
- Push latency: `count`/flags update on the edge after `sample_valid`.
- Pop latency: 1 cycle from the `rd_en` edge to `rd_valid` and data. Back-to-back `rd_en` yields one entry per cycle.
- `rd_valid` lasts exactly one cycle per accepted pop. Data holds until the next accepted pop or reset.
- Write-then-read of the same slot: an entry pushed in cycle N is poppable from cycle N+1.

## Structure
- Shared package `accel_pkg`:
  - `accel_sample_t` packed struct {x,y,z} of `logic[15:0]`.
  - `AXIS_W = 16`, `SAMPLE_W = 48`.
  - This package is also adopted by the signal path outputs.
- Sub-module `sample_ram`: DEPTH x SAMPLE_W simple dual-port RAM with one synchronous write port and a registered read port, inferable to block RAM. Pointer/count/flag logic stays in `accel_sample_fifo`.

## Test plan
- After reset: `empty`=1, `count`=0; `rd_en` pulse → no `rd_valid`, `count` stays 0.
- Push 3 samples (x=0x0001..0x0003, y=0x8000, z=0xFFFF), then 3 pops → `rd_valid` ×3, 1 cycle after each `rd_en`, x=1,2,3 in order, `empty`=1 at the end.
- Push 8 with WATERMARK=8 → `watermark_irq` rises on the edge after the 8th push. One pop → it falls.
- Fill 16, then push 300 more → `full`=1, `overflow`=1, `overflow_count`=255. Drain 16 → the original 16 values come out unaltered.
- While full, same-cycle push and pop → `count` stays 16, `overflow_count` unchanged. The popped entry is the oldest; the new entry emerges last.
- With `count`=5, assert `clear` together with `sample_valid` and `rd_en` → `count`=0, no `rd_valid`, `overflow`=0. Then assert `reset_n` low mid-stream → all outputs return to reset values without a clock edge.
